// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
// MEM-stage controller. Takes the EX/MEM pipeline register (*_M), runs the
// load/store on a req/ack data-memory bus, stalls upstream while the bus
// transaction is open, and produces the MEM/WB pipeline register (*_W).
// Misaligned accesses and bus timeouts are reported on a one-cycle mem_err.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   RegW_enable_M .. RDadd_M      EX/MEM register contents
//   stall_M                       hold EX/MEM and earlier stages (combinational)
//   dmem_req/we/addr/wdata        registered bus request
//   dmem_ack, dmem_rdata          bus completion and load data
//   RegW_enable_W .. RDadd_W      MEM/WB register contents
//   mem_err                       one-cycle pulse: misaligned or timed out
//
// Parameter
//   TIMEOUT   ACCESS cycles without ack before the access is aborted;
//             0 disables the timeout.
// ---------------------------------------------------------------------------
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegW_enable_M,
  input  logic        Mem_Write_M,
  input  logic        Mem_Read_M,
  input  logic        Result_src_M,
  input  logic [31:0] ALU_result_M,
  input  logic [31:0] Write_Data_M,
  input  logic [4:0]  RDadd_M,
  output logic        stall_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        RegW_enable_W,
  output logic        Result_src_W,
  output logic [31:0] ALU_result_W,
  output logic [31:0] Read_Data_W,
  output logic [4:0]  RDadd_W,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Counter only needs to reach TIMEOUT-1; the abort fires on that cycle.
  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          TMO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;     // data captured on ack
  logic          tmo_q, tmo_d;         // current transaction timed out
  logic          regw_w_q, regw_w_d;
  logic          rsrc_w_q, rsrc_w_d;
  logic [31:0]   alu_w_q, alu_w_d;
  logic [31:0]   rdata_w_q, rdata_w_d;
  logic [4:0]    rd_w_q, rd_w_d;
  logic          err_q, err_d;

  logic mem_op;
  logic aligned;
  logic start_acc;
  logic tmo_hit;

  assign mem_op    = Mem_Read_M | Mem_Write_M;
  assign aligned   = (ALU_result_M[1:0] == 2'b00);
  assign start_acc = (state_q == S_IDLE) & mem_op & aligned;
  assign tmo_hit   = TMO_EN && (cnt_q == CNT_LAST);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_acc) state_d = S_ACCESS;
      S_ACCESS: if (dmem_ack || tmo_hit) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;   // the load/store on *_M retires now
      default:  state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next-value logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    stall_M   = start_acc | (state_q == S_ACCESS);
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
    regw_w_d  = regw_w_q;
    rsrc_w_d  = rsrc_w_q;
    alu_w_d   = alu_w_q;
    rdata_w_d = rdata_w_q;
    rd_w_d    = rd_w_q;

    // Bus side
    unique case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          req_d   = 1'b1;
          we_d    = Mem_Write_M;       // read+write together is a write
          addr_d  = {ALU_result_M[31:2], 2'b00};
          wdata_d = Write_Data_M;
          cnt_d   = '0;
          tmo_d   = 1'b0;
        end
      end
      S_ACCESS: begin
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
          req_d   = 1'b0;
        end else if (tmo_hit) begin
          req_d   = 1'b0;
          tmo_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE:  cnt_d = '0;
      default: ;
    endcase

    // MEM/WB register: bubble while stalled, otherwise take *_M
    if (stall_M) begin
      regw_w_d = 1'b0;
      rsrc_w_d = 1'b0;
    end else begin
      regw_w_d  = RegW_enable_M;
      rsrc_w_d  = Result_src_M;
      alu_w_d   = ALU_result_M;
      rd_w_d    = RDadd_M;
      rdata_w_d = '0;
      if (state_q == S_DONE) begin
        if (tmo_q)      regw_w_d  = 1'b0;
        else if (!we_q) rdata_w_d = rdata_q;
      end else if (mem_op && !aligned) begin
        // Misaligned: retire without a bus cycle and without a write-back.
        regw_w_d = 1'b0;
        err_d    = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      tmo_q     <= 1'b0;
      regw_w_q  <= 1'b0;
      rsrc_w_q  <= 1'b0;
      alu_w_q   <= '0;
      rdata_w_q <= '0;
      rd_w_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      tmo_q     <= tmo_d;
      regw_w_q  <= regw_w_d;
      rsrc_w_q  <= rsrc_w_d;
      alu_w_q   <= alu_w_d;
      rdata_w_q <= rdata_w_d;
      rd_w_q    <= rd_w_d;
      err_q     <= err_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign RegW_enable_W = regw_w_q;
  assign Result_src_W  = rsrc_w_q;
  assign ALU_result_W  = alu_w_q;
  assign Read_Data_W   = rdata_w_q;
  assign RDadd_W       = rd_w_q;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Directed bench for mem_stage_ctrl: ALU pass-through, load, store with wait
// states, misaligned access, timeout, and reset in the middle of an access.
// Outputs are sampled 1 ns after the rising edge; inputs change there too.
// ---------------------------------------------------------------------------
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegW_enable_M, Mem_Write_M, Mem_Read_M, Result_src_M;
  logic [31:0] ALU_result_M, Write_Data_M;
  logic [4:0]  RDadd_M;
  logic        stall_M;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        RegW_enable_W, Result_src_W;
  logic [31:0] ALU_result_W, Read_Data_W;
  logic [4:0]  RDadd_W;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(15)) dut (
    .clk           (clk),
    .rst           (rst),
    .RegW_enable_M (RegW_enable_M),
    .Mem_Write_M   (Mem_Write_M),
    .Mem_Read_M    (Mem_Read_M),
    .Result_src_M  (Result_src_M),
    .ALU_result_M  (ALU_result_M),
    .Write_Data_M  (Write_Data_M),
    .RDadd_M       (RDadd_M),
    .stall_M       (stall_M),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .RegW_enable_W (RegW_enable_W),
    .Result_src_W  (Result_src_W),
    .ALU_result_W  (ALU_result_W),
    .Read_Data_W   (Read_Data_W),
    .RDadd_W       (RDadd_W),
    .mem_err       (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic regw, input logic rd_en, input logic wr_en,
                        input logic rsrc, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] rd);
    RegW_enable_M = regw;
    Mem_Read_M    = rd_en;
    Mem_Write_M   = wr_en;
    Result_src_M  = rsrc;
    ALU_result_M  = alu;
    Write_Data_M  = wd;
    RDadd_M       = rd;
  endtask

  task automatic nop();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  // Runs the stall window of one memory instruction already on *_M.
  // ack_at = request cycle (1-based) in which ack is driven; 0 = never.
  // Returns with the DUT in its first non-stalled cycle (DONE).
  task automatic run_mem(input int ack_at, input logic [31:0] rdat,
                         output int n_stall, output int n_req, output int n_err,
                         output int n_regw, output bit stable,
                         output logic [31:0] a0, output logic [31:0] w0,
                         output logic we0);
    n_stall = 0; n_req = 0; n_err = 0; n_regw = 0; stable = 1'b1;
    a0 = '0; w0 = '0; we0 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!stall_M) break;
      n_stall++;
      if (mem_err) n_err++;
      if (i > 0 && RegW_enable_W) n_regw++;
      if (dmem_req) begin
        if (n_req == 0) begin
          a0 = dmem_addr; w0 = dmem_wdata; we0 = dmem_we;
        end else if (dmem_addr !== a0 || dmem_wdata !== w0 || dmem_we !== we0) begin
          stable = 1'b0;
        end
        n_req++;
        if (ack_at != 0 && n_req == ack_at) begin
          dmem_ack   = 1'b1;
          dmem_rdata = rdat;
        end
      end
      tick();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
    end
    if (mem_err) n_err++;
  endtask

  int          n_stall, n_req, n_err, n_regw;
  bit          stable;
  logic [31:0] a0, w0;
  logic        we0;

  initial begin
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    nop();
    #2;
    check("rst_req",   dmem_req, 0);
    check("rst_regw",  RegW_enable_W, 0);
    check("rst_alu_w", ALU_result_W, 0);
    check("rst_err",   mem_err, 0);
    tick();
    rst = 1'b0;

    // ALU op passes straight through in one cycle
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5);
    #1 check("alu_stall", stall_M, 0);
    tick();
    check("alu_regw", RegW_enable_W, 1);
    check("alu_rd",   RDadd_W, 5);
    check("alu_res",  ALU_result_W, 32'h1234);
    check("alu_stall_after", stall_M, 0);

    // Load @0x100, ack in first ACCESS cycle
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd7);
    #1;
    run_mem(1, 32'hDEADBEEF, n_stall, n_req, n_err, n_regw, stable, a0, w0, we0);
    check("ld_stall",  n_stall, 2);
    check("ld_req",    n_req, 1);
    check("ld_addr",   a0, 32'h100);
    check("ld_we",     we0, 0);
    check("ld_bubble", n_regw, 0);
    check("ld_err",    n_err, 0);
    check("ld_req_done", dmem_req, 0);
    tick();
    nop();
    check("ld_rdata", Read_Data_W, 32'hDEADBEEF);
    check("ld_rsrc",  Result_src_W, 1);
    check("ld_regw",  RegW_enable_W, 1);
    check("ld_rd",    RDadd_W, 7);

    // Load that never gets an ack: 15 ACCESS cycles then abort
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd3);
    #1;
    run_mem(0, 32'h0, n_stall, n_req, n_err, n_regw, stable, a0, w0, we0);
    check("to_req",   n_req, 15);
    check("to_stall", n_stall, 16);
    check("to_err",   n_err, 1);
    check("to_req_done", dmem_req, 0);
    tick();
    nop();
    check("to_regw",  RegW_enable_W, 0);
    check("to_rdata", Read_Data_W, 0);
    check("to_err_gone", mem_err, 0);

    // Store @0x20, ack after 3 wait cycles
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'hA5A5A5A5, 5'd0);
    #1;
    run_mem(4, 32'h0, n_stall, n_req, n_err, n_regw, stable, a0, w0, we0);
    check("st_req",    n_req, 4);
    check("st_stall",  n_stall, 5);
    check("st_stable", stable, 1);
    check("st_we",     we0, 1);
    check("st_wdata",  w0, 32'hA5A5A5A5);
    check("st_addr",   a0, 32'h20);
    check("st_bubble", n_regw, 0);
    tick();
    nop();
    check("st_rdata", Read_Data_W, 0);
    check("st_regw",  RegW_enable_W, 0);

    // Misaligned load @0x102
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 5'd9);
    #1 check("mis_stall", stall_M, 0);
    tick();
    nop();
    check("mis_req",   dmem_req, 0);
    check("mis_err",   mem_err, 1);
    check("mis_regw",  RegW_enable_W, 0);
    check("mis_rdata", Read_Data_W, 0);
    check("mis_rd",    RDadd_W, 9);
    tick();
    check("mis_err_pulse", mem_err, 0);
    check("mis_req2",      dmem_req, 0);

    // Reset in the second ACCESS cycle
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 5'd4);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 5'd6);
    tick();                       // ACCESS cycle 1
    tick();                       // ACCESS cycle 2
    check("rs_req_before", dmem_req, 1);
    rst = 1'b1;
    #1;
    check("rs_req",   dmem_req, 0);
    check("rs_alu_w", ALU_result_W, 0);
    check("rs_rd_w",  RDadd_W, 0);
    check("rs_regw",  RegW_enable_W, 0);
    check("rs_err",   mem_err, 0);
    nop();
    #2 rst = 1'b0;
    tick();
    check("rs_err_after", mem_err, 0);
    set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h84, 32'h0, 5'd8);
    #1;
    run_mem(1, 32'h0BADF00D, n_stall, n_req, n_err, n_regw, stable, a0, w0, we0);
    check("rs_ld_stall", n_stall, 2);
    check("rs_ld_addr",  a0, 32'h84);
    tick();
    nop();
    check("rs_ld_rdata", Read_Data_W, 32'h0BADF00D);
    check("rs_ld_rd",    RDadd_W, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
